// File: rtl/program_sequencer.sv
// program_sequencer
// Multi-cycle fetch/decode/execute controller for the 16-bit-instruction core.
// Presents the PC and the latched program select to instruction memory and
// captures the fetched word into IR. Each instruction then steps through
// DECODE, EXECUTE and WRITEBACK. The register file and the ALU sit outside
// this block: it only drives their addresses, the ALU opcode and the
// writeback controls.
// Execution stops on HALT, on an undefined opcode, or when the last word of
// the program has retired without a HALT.

module program_sequencer #(
    parameter int PROG_DEPTH = 128,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        programSelectIn,
    input  logic [15:0]       instruction,
    output logic [ADDR_W-1:0] address,
    output logic [1:0]        programSelect,
    output logic [3:0]        regReadA,
    output logic [3:0]        regReadB,
    output logic [3:0]        aluOp,
    output logic [7:0]        immValue,
    output logic              immSelect,
    output logic              regWriteEn,
    output logic [3:0]        regWriteAddr,
    output logic              busy,
    output logic              halted,
    output logic              illegalOp,
    output logic              pcOverrun
);

    // Opcode encodings
    localparam logic [3:0] OP_SETC = 4'b0000;
    localparam logic [3:0] OP_COPY = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_NEG  = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1000;
    localparam logic [3:0] OP_GT   = 4'b1011;
    localparam logic [3:0] OP_HALT = 4'b1110;

    // Last legal PC. No fetch is ever issued beyond it.
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALTED    = 3'd5
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [1:0]        r_prog_sel;
    logic [15:0]       r_ir;
    logic              r_write_en;
    logic              r_imm_sel;
    logic              r_busy;
    logic              r_halted;
    logic              r_illegal;
    logic              r_overrun;

    logic [3:0]        w_op;
    logic              w_op_legal;

    // HALT is listed as legal here. DECODE tests for HALT before it tests
    // legality, so HALT never reaches EXECUTE.
    function automatic logic f_opcode_legal(input logic [3:0] op);
        logic legal;
        case (op)
            OP_SETC, OP_COPY, OP_ADD, OP_NEG, OP_AND,
            OP_OR, OP_SHL, OP_GT, OP_HALT: legal = 1'b1;
            default:                       legal = 1'b0;
        endcase
        return legal;
    endfunction

    assign w_op       = r_ir[15:12];
    assign w_op_legal = f_opcode_legal(w_op);

    // Sequencer FSM. All control outputs are registered and are set on the
    // edge that enters the state in which they must be seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_prog_sel <= 2'b00;
            r_ir       <= 16'h0000;
            r_write_en <= 1'b0;
            r_imm_sel  <= 1'b0;
            r_busy     <= 1'b0;
            r_halted   <= 1'b0;
            r_illegal  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            // Writeback controls are high only in the single WRITEBACK cycle.
            r_write_en <= 1'b0;
            r_imm_sel  <= 1'b0;
            case (r_state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        r_state    <= S_FETCH;
                        r_pc       <= '0;
                        r_prog_sel <= programSelectIn;
                        r_illegal  <= 1'b0;
                        r_overrun  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_halted   <= 1'b0;
                    end else begin
                        r_state    <= r_state;
                    end
                end
                S_FETCH: begin
                    r_ir    <= instruction;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (w_op == OP_HALT) begin
                        r_state  <= S_HALTED;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else if (!w_op_legal) begin
                        r_state   <= S_HALTED;
                        r_busy    <= 1'b0;
                        r_halted  <= 1'b1;
                        r_illegal <= 1'b1;
                    end else begin
                        r_state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    r_state    <= S_WRITEBACK;
                    r_write_en <= 1'b1;
                    r_imm_sel  <= (w_op == OP_SETC);
                end
                S_WRITEBACK: begin
                    if (r_pc == LAST_PC) begin
                        // Out of program space without a HALT. The PC stays put.
                        r_state   <= S_HALTED;
                        r_busy    <= 1'b0;
                        r_halted  <= 1'b1;
                        r_overrun <= 1'b1;
                    end else begin
                        r_pc    <= r_pc + ADDR_W'(1);
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign address       = r_pc;
    assign programSelect = r_prog_sel;
    assign aluOp         = r_ir[15:12];
    assign regWriteAddr  = r_ir[11:8];
    assign regReadA      = r_ir[7:4];
    assign regReadB      = r_ir[3:0];
    assign immValue      = r_ir[7:0];
    assign immSelect     = r_imm_sel;
    // A reset that arrives during WRITEBACK cancels the write in that cycle,
    // so the registered strobe is masked by reset.
    assign regWriteEn    = r_write_en & ~reset;
    assign busy          = r_busy;
    assign halted        = r_halted;
    assign illegalOp     = r_illegal;
    assign pcOverrun     = r_overrun;

endmodule
